// File: rtl/stage_5_byte_buffer_if.sv
// Handshake bundle between the carry-propagation stage, the byte buffer and the external byte sink.
// The buffer uses the slave modport; the upstream/sink side uses the master modport.
interface stage_5_byte_buffer_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 24
);
  logic [1:0]             in_flag;
  logic                   in_final;
  logic [DATA_WIDTH-1:0]  in_byte_1;
  logic [DATA_WIDTH-1:0]  in_byte_2;
  logic [DATA_WIDTH-1:0]  in_byte_3;
  logic                   out_stall;
  logic                   out_valid;
  logic                   out_ready;
  logic [DATA_WIDTH-1:0]  out_byte;
  logic                   out_last;
  logic                   out_done;
  logic [COUNT_WIDTH-1:0] out_byte_count;
  logic                   out_error;

  modport master (
    output in_flag, in_final, in_byte_1, in_byte_2, in_byte_3, out_ready,
    input  out_stall, out_valid, out_byte, out_last, out_done, out_byte_count, out_error
  );

  modport slave (
    input  in_flag, in_final, in_byte_1, in_byte_2, in_byte_3, out_ready,
    output out_stall, out_valid, out_byte, out_last, out_done, out_byte_count, out_error
  );
endinterface

// File: rtl/stage_5_byte_buffer.sv
// Circular byte FIFO behind the carry stage: takes 0-3 bytes per cycle, drains one byte per cycle
// over valid/ready, tags the frame's final byte and counts emitted bytes.
module stage_5_byte_buffer #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 4,
  parameter int COUNT_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  stage_5_byte_buffer_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef logic [ADDR_WIDTH-1:0] ptr_t;
  typedef logic [ADDR_WIDTH:0]   cnt_t;

  localparam cnt_t DEPTH_C = cnt_t'(DEPTH);

  ptr_t                   wr_ptr_q, wr_ptr_d;
  ptr_t                   rd_ptr_q, rd_ptr_d;
  cnt_t                   count_q, count_d;
  logic                   done_q, done_d;
  logic                   final_seen_q, final_seen_d;
  logic                   error_q, error_d;
  logic [COUNT_WIDTH-1:0] byte_cnt_q, byte_cnt_d;

  logic [DATA_WIDTH-1:0]  mem_q [DEPTH];
  logic [DEPTH-1:0]       tag_q;

  cnt_t                   free_slots;
  logic [1:0]             push_n;
  logic                   push_req;
  logic                   push_ok;
  logic                   fifo_valid;
  logic                   pop;

  logic [DATA_WIDTH-1:0]  lane_byte [3];
  ptr_t                   lane_addr [3];
  logic [2:0]             lane_we;
  logic [2:0]             lane_tag;

  // Flag encoding is not binary: 10 means three bytes, 11 means two.
  always_comb begin
    push_n = 2'd0;
    case (bus.in_flag)
      2'b01:   push_n = 2'd1;
      2'b11:   push_n = 2'd2;
      2'b10:   push_n = 2'd3;
      default: push_n = 2'd0;
    endcase
  end

  assign free_slots = DEPTH_C - count_q;
  assign push_req   = (push_n != 2'd0);
  // Space check uses the registered count only; a same-cycle pop never rescues a push.
  assign push_ok    = push_req && (free_slots >= cnt_t'(push_n)) && !done_q && !final_seen_q;
  assign fifo_valid = (count_q != '0);
  assign pop        = fifo_valid && bus.out_ready;

  assign lane_byte[0] = bus.in_byte_1;
  assign lane_byte[1] = bus.in_byte_2;
  assign lane_byte[2] = bus.in_byte_3;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_lane
      assign lane_addr[gi] = wr_ptr_q + ptr_t'(gi);
      assign lane_we[gi]   = push_ok && (2'(gi) < push_n);
      assign lane_tag[gi]  = bus.in_final && (2'(gi) == (push_n - 2'd1));
    end
  endgenerate

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    done_d       = done_q;
    final_seen_d = final_seen_q;
    error_d      = error_q;
    byte_cnt_d   = byte_cnt_q;

    if (push_ok) begin
      wr_ptr_d     = wr_ptr_q + ptr_t'(push_n);
      final_seen_d = final_seen_q | bus.in_final;
    end

    if ((push_req && !push_ok) || (bus.in_final && !push_req)) begin
      error_d = 1'b1;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + ptr_t'(1);
      if (tag_q[rd_ptr_q]) begin
        done_d = 1'b1;
      end
      if (byte_cnt_q != '1) begin
        byte_cnt_d = byte_cnt_q + 1'b1;
      end
    end

    count_d = count_q + (push_ok ? cnt_t'(push_n) : '0) - cnt_t'(pop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      done_q       <= 1'b0;
      final_seen_q <= 1'b0;
      error_q      <= 1'b0;
      byte_cnt_q   <= '0;
      tag_q        <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      done_q       <= done_d;
      final_seen_q <= final_seen_d;
      error_q      <= error_d;
      byte_cnt_q   <= byte_cnt_d;
      for (int k = 0; k < 3; k++) begin
        if (lane_we[k]) begin
          tag_q[lane_addr[k]] <= lane_tag[k];
        end
      end
    end
  end

  // Payload storage needs no reset: the head byte is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (lane_we[k]) begin
        mem_q[lane_addr[k]] <= lane_byte[k];
      end
    end
  end

  assign bus.out_valid      = fifo_valid;
  assign bus.out_byte       = fifo_valid ? mem_q[rd_ptr_q] : '0;
  assign bus.out_last       = fifo_valid & tag_q[rd_ptr_q];
  assign bus.out_stall      = (free_slots < cnt_t'(3));
  assign bus.out_done       = done_q;
  assign bus.out_byte_count = byte_cnt_q;
  assign bus.out_error      = error_q;
endmodule

// File: tb/tb_stage_5_byte_buffer.sv
// Directed bench for the output byte buffer: single/triple pushes, final tagging, fill and stall,
// wrap-around with a random sink, push+pop at near-full, and asynchronous reset mid-frame.
module tb_stage_5_byte_buffer;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  stage_5_byte_buffer_if #(.DATA_WIDTH(8), .COUNT_WIDTH(24)) bus ();

  stage_5_byte_buffer #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .COUNT_WIDTH(24)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_flag   = 2'b00;
    bus.in_final  = 1'b0;
    bus.in_byte_1 = 8'h00;
    bus.in_byte_2 = 8'h00;
    bus.in_byte_3 = 8'h00;
    bus.out_ready = 1'b0;
  endtask

  task automatic apply_reset();
    idle();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b0;
    tick();
    tick();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", bus.out_valid); end
    total++; if (bus.out_last !== 1'b0) begin bad++; $display("FAIL rst_last: got %b want 0", bus.out_last); end
    total++; if (bus.out_stall !== 1'b0) begin bad++; $display("FAIL rst_stall: got %b want 0", bus.out_stall); end
    total++; if (bus.out_byte !== 8'h00) begin bad++; $display("FAIL rst_byte: got %h want 00", bus.out_byte); end
    total++; if (bus.out_done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", bus.out_done); end
    total++; if (bus.out_byte_count !== 24'd0) begin bad++; $display("FAIL rst_count: got %0d want 0", bus.out_byte_count); end
    total++; if (bus.out_error !== 1'b0) begin bad++; $display("FAIL rst_error: got %b want 0", bus.out_error); end
    reset = 1'b1;
    $display("test_reset: outputs checked in reset");
  endtask

  task automatic test_single_push();
    apply_reset();
    bus.in_flag = 2'b01; bus.in_byte_1 = 8'h11; bus.out_ready = 1'b1;
    tick();
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL t1_valid: got %b want 1", bus.out_valid); end
    total++; if (bus.out_byte !== 8'h11) begin bad++; $display("FAIL t1_byte0: got %h want 11", bus.out_byte); end
    bus.in_byte_1 = 8'h22;
    tick();
    total++; if (bus.out_byte !== 8'h22) begin bad++; $display("FAIL t1_byte1: got %h want 22", bus.out_byte); end
    bus.in_byte_1 = 8'h33;
    tick();
    total++; if (bus.out_byte !== 8'h33) begin bad++; $display("FAIL t1_byte2: got %h want 33", bus.out_byte); end
    bus.in_flag = 2'b00;
    tick();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL t1_empty: got %b want 0", bus.out_valid); end
    total++; if (bus.out_byte_count !== 24'd3) begin bad++; $display("FAIL t1_count: got %0d want 3", bus.out_byte_count); end
    total++; if (bus.out_error !== 1'b0) begin bad++; $display("FAIL t1_error: got %b want 0", bus.out_error); end
    $display("test_single_push: 3 bytes streamed");
  endtask

  task automatic test_triple_final();
    apply_reset();
    bus.in_flag = 2'b10; bus.in_final = 1'b1;
    bus.in_byte_1 = 8'hAA; bus.in_byte_2 = 8'hBB; bus.in_byte_3 = 8'hCC;
    tick();
    total++; if (bus.out_byte !== 8'hAA) begin bad++; $display("FAIL t2_head: got %h want aa", bus.out_byte); end
    total++; if (bus.out_last !== 1'b0) begin bad++; $display("FAIL t2_last_aa: got %b want 0", bus.out_last); end
    total++; if (bus.out_error !== 1'b0) begin bad++; $display("FAIL t2_err0: got %b want 0", bus.out_error); end
    bus.in_flag = 2'b01; bus.in_final = 1'b0; bus.in_byte_1 = 8'hDD;
    tick();
    total++; if (bus.out_error !== 1'b1) begin bad++; $display("FAIL t2_postfinal_err: got %b want 1", bus.out_error); end
    bus.in_flag = 2'b00; bus.out_ready = 1'b1;
    tick();
    total++; if (bus.out_byte !== 8'hBB) begin bad++; $display("FAIL t2_bb: got %h want bb", bus.out_byte); end
    total++; if (bus.out_last !== 1'b0) begin bad++; $display("FAIL t2_last_bb: got %b want 0", bus.out_last); end
    tick();
    total++; if (bus.out_byte !== 8'hCC) begin bad++; $display("FAIL t2_cc: got %h want cc", bus.out_byte); end
    total++; if (bus.out_last !== 1'b1) begin bad++; $display("FAIL t2_last_cc: got %b want 1", bus.out_last); end
    total++; if (bus.out_done !== 1'b0) begin bad++; $display("FAIL t2_done_early: got %b want 0", bus.out_done); end
    tick();
    total++; if (bus.out_done !== 1'b1) begin bad++; $display("FAIL t2_done: got %b want 1", bus.out_done); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL t2_valid_after: got %b want 0", bus.out_valid); end
    total++; if (bus.out_byte_count !== 24'd3) begin bad++; $display("FAIL t2_count: got %0d want 3", bus.out_byte_count); end
    tick();
    total++; if (bus.out_done !== 1'b1) begin bad++; $display("FAIL t2_done_sticky: got %b want 1", bus.out_done); end
    $display("test_triple_final: frame of 3 bytes closed");
  endtask

  task automatic test_final_empty();
    apply_reset();
    bus.in_final = 1'b1;
    tick();
    total++; if (bus.out_error !== 1'b1) begin bad++; $display("FAIL tf_err: got %b want 1", bus.out_error); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL tf_valid: got %b want 0", bus.out_valid); end
    bus.in_final = 1'b0; bus.in_flag = 2'b01; bus.in_byte_1 = 8'h77;
    tick();
    total++; if (bus.out_byte !== 8'h77) begin bad++; $display("FAIL tf_next_push: got %h want 77", bus.out_byte); end
    total++; if (bus.out_last !== 1'b0) begin bad++; $display("FAIL tf_last: got %b want 0", bus.out_last); end
    $display("test_final_empty: empty final flagged");
  endtask

  task automatic test_fill_stall();
    apply_reset();
    for (int i = 0; i < 14; i++) begin
      bus.in_flag = 2'b01; bus.in_byte_1 = 8'(i);
      tick();
      total++; if (bus.out_stall !== (i >= 13)) begin bad++; $display("FAIL t3_stall_%0d: got %b want %b", i, bus.out_stall, (i >= 13)); end
    end
    total++; if (bus.out_error !== 1'b0) begin bad++; $display("FAIL t3_err0: got %b want 0", bus.out_error); end
    bus.in_flag = 2'b10; bus.in_byte_1 = 8'hE0; bus.in_byte_2 = 8'hE1; bus.in_byte_3 = 8'hE2;
    tick();
    total++; if (bus.out_error !== 1'b1) begin bad++; $display("FAIL t3_overflow_err: got %b want 1", bus.out_error); end
    bus.in_flag = 2'b11; bus.in_byte_1 = 8'h0E; bus.in_byte_2 = 8'h0F;
    tick();
    total++; if (bus.out_stall !== 1'b1) begin bad++; $display("FAIL t3_full_stall: got %b want 1", bus.out_stall); end
    bus.in_flag = 2'b00; bus.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      total++; if (bus.out_byte !== 8'(i) || bus.out_valid !== 1'b1) begin bad++; $display("FAIL t3_drain_%0d: got %h/%b want %h/1", i, bus.out_byte, bus.out_valid, 8'(i)); end
      total++; if (bus.out_stall !== (i <= 2)) begin bad++; $display("FAIL t3_drain_stall_%0d: got %b want %b", i, bus.out_stall, (i <= 2)); end
      tick();
    end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL t3_empty: got %b want 0", bus.out_valid); end
    $display("test_fill_stall: filled to 16, drained 16");
  endtask

  task automatic test_wrap_random();
    int tx, rx, cyc, k, n;
    int nseq [4];
    nseq[0] = 1; nseq[1] = 3; nseq[2] = 2; nseq[3] = 3;
    tx = 0; rx = 0; cyc = 0; k = 0;
    apply_reset();
    while (rx < 40 && cyc < 2000) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      if (bus.out_valid && bus.out_ready) begin
        total++; if (bus.out_byte !== 8'(rx) || bus.out_last !== 1'b0) begin bad++; $display("FAIL t4_pop_%0d: got %h last %b want %h last 0", rx, bus.out_byte, bus.out_last, 8'(rx)); end
        $display("t4 pop byte=%h", bus.out_byte);
        rx++;
      end
      if (tx < 40 && !bus.out_stall) begin
        n = nseq[k % 4];
        k++;
        if (n > 40 - tx) n = 40 - tx;
        bus.in_flag   = (n == 1) ? 2'b01 : (n == 2) ? 2'b11 : 2'b10;
        bus.in_byte_1 = 8'(tx);
        bus.in_byte_2 = 8'(tx + 1);
        bus.in_byte_3 = 8'(tx + 2);
        tx += n;
      end else begin
        bus.in_flag = 2'b00;
      end
      tick();
      cyc++;
    end
    idle();
    total++; if (rx != 40) begin bad++; $display("FAIL t4_timeout: got %0d bytes want 40", rx); end
    total++; if (bus.out_error !== 1'b0) begin bad++; $display("FAIL t4_error: got %b want 0", bus.out_error); end
    total++; if (bus.out_byte_count !== 24'd40) begin bad++; $display("FAIL t4_count: got %0d want 40", bus.out_byte_count); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL t4_empty: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_push_pop_same();
    apply_reset();
    for (int t = 0; t < 5; t++) begin
      bus.in_flag   = 2'b10;
      bus.in_byte_1 = 8'(8'h40 + 3 * t);
      bus.in_byte_2 = 8'(8'h41 + 3 * t);
      bus.in_byte_3 = 8'(8'h42 + 3 * t);
      tick();
    end
    total++; if (bus.out_stall !== 1'b1) begin bad++; $display("FAIL t5_stall15: got %b want 1", bus.out_stall); end
    total++; if (bus.out_error !== 1'b0) begin bad++; $display("FAIL t5_err0: got %b want 0", bus.out_error); end
    total++; if (bus.out_byte !== 8'h40) begin bad++; $display("FAIL t5_head: got %h want 40", bus.out_byte); end
    bus.in_flag = 2'b01; bus.in_byte_1 = 8'h4F; bus.out_ready = 1'b1;
    tick();
    total++; if (bus.out_byte !== 8'h41) begin bad++; $display("FAIL t5_head2: got %h want 41", bus.out_byte); end
    total++; if (bus.out_error !== 1'b0) begin bad++; $display("FAIL t5_err_pushpop: got %b want 0", bus.out_error); end
    bus.in_flag = 2'b11; bus.in_byte_1 = 8'hE0; bus.in_byte_2 = 8'hE1;
    tick();
    total++; if (bus.out_error !== 1'b1) begin bad++; $display("FAIL t5_drop_err: got %b want 1", bus.out_error); end
    total++; if (bus.out_stall !== 1'b1) begin bad++; $display("FAIL t5_stall14: got %b want 1", bus.out_stall); end
    bus.in_flag = 2'b00;
    for (int i = 0; i < 14; i++) begin
      total++; if (bus.out_byte !== 8'(8'h42 + i) || bus.out_valid !== 1'b1) begin bad++; $display("FAIL t5_drain_%0d: got %h/%b want %h/1", i, bus.out_byte, bus.out_valid, 8'(8'h42 + i)); end
      tick();
    end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL t5_empty: got %b want 0", bus.out_valid); end
    total++; if (bus.out_byte_count !== 24'd16) begin bad++; $display("FAIL t5_count: got %0d want 16", bus.out_byte_count); end
    $display("test_push_pop_same: near-full push/pop done");
  endtask

  task automatic test_reset_mid_frame();
    apply_reset();
    bus.in_flag = 2'b10; bus.in_byte_1 = 8'h50; bus.in_byte_2 = 8'h51; bus.in_byte_3 = 8'h52;
    tick();
    bus.in_flag = 2'b11; bus.in_byte_1 = 8'h53; bus.in_byte_2 = 8'h54;
    tick();
    bus.in_flag = 2'b00;
    total++; if (bus.out_byte !== 8'h50) begin bad++; $display("FAIL t6_head: got %h want 50", bus.out_byte); end
    #3;
    reset = 1'b0;
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL t6_async_valid: got %b want 0", bus.out_valid); end
    total++; if (bus.out_byte !== 8'h00) begin bad++; $display("FAIL t6_async_byte: got %h want 00", bus.out_byte); end
    total++; if (bus.out_stall !== 1'b0) begin bad++; $display("FAIL t6_async_stall: got %b want 0", bus.out_stall); end
    tick();
    reset = 1'b1;
    bus.in_flag = 2'b01; bus.in_byte_1 = 8'h5A;
    tick();
    total++; if (bus.out_byte !== 8'h5A || bus.out_valid !== 1'b1) begin bad++; $display("FAIL t6_first: got %h/%b want 5a/1", bus.out_byte, bus.out_valid); end
    bus.in_flag = 2'b00; bus.out_ready = 1'b1;
    tick();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL t6_empty: got %b want 0", bus.out_valid); end
    total++; if (bus.out_byte_count !== 24'd1) begin bad++; $display("FAIL t6_count: got %0d want 1", bus.out_byte_count); end
    $display("test_reset_mid_frame: contents discarded");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_push();
    test_triple_final();
    test_final_empty();
    test_fill_stall();
    test_wrap_random();
    test_push_pop_same();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
